// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage load/store sequencer over a single-port req/ack data bus.
//   clk, rst (async, active-low)
//   pipeline in : req_valid_i, op_i, addr_i, wdata_i, flush_i
//   bus out     : bus_req_o, bus_we_o, bus_addr_o, bus_sel_o (big-endian lanes), bus_wdata_o
//   bus in      : bus_ack_i, bus_rdata_i
//   pipeline out: stallreq_o, ldata_o, ldata_valid_o, misalign_o
module mem_bus_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] ldata_o,
  output logic              ldata_valid_o,
  output logic              misalign_o
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic [1:0] lane_q;
  logic killed, is_word, is_half, is_store, aligned, launch, ld_hit;
  logic [3:0] sel;
  logic [DATA_W-1:0] wd, ext;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign is_word  = op_i == 3'b100 || op_i == 3'b111;
  assign is_half  = op_i == 3'b010 || op_i == 3'b011 || op_i == 3'b110;
  assign is_store = op_i[2] & (op_i[1] | op_i[0]);
  assign aligned  = is_word ? addr_i[1:0] == 2'b00 : is_half ? !addr_i[0] : 1'b1;
  assign launch   = state == IDLE && req_valid_i && !flush_i && aligned;
  assign misalign_o = rst && state == IDLE && req_valid_i && !flush_i && !aligned;
  assign stallreq_o = rst && (launch || state == BUS);
  assign bus_req_o  = state == BUS;
  assign sel = is_word ? 4'b1111 : is_half ? (addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> addr_i[1:0];
  assign wd  = op_i == 3'b101 ? {4{wdata_i[7:0]}} : op_i == 3'b110 ? {2{wdata_i[15:0]}} : wdata_i;
  // lane 00 is the most significant byte, hence the inverted lane index
  assign byte_v = bus_rdata_i[{~lane_q, 3'b000} +: 8];
  assign half_v = lane_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
  assign ext = op_q == 3'b000 ? {{(DATA_W-8){byte_v[7]}}, byte_v} :
               op_q == 3'b001 ? {{(DATA_W-8){1'b0}}, byte_v} :
               op_q == 3'b010 ? {{(DATA_W-16){half_v[15]}}, half_v} :
               op_q == 3'b011 ? {{(DATA_W-16){1'b0}}, half_v} : bus_rdata_i;
  // a flush arriving in the ack cycle itself still kills the load
  assign ld_hit = state == BUS && bus_ack_i && !(killed || flush_i) && !(op_q[2] & (op_q[1] | op_q[0]));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = launch ? BUS : IDLE;
    else if (state == BUS) state_n = !bus_ack_i ? BUS : (killed || flush_i) ? IDLE : DONE;
    else state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_sel_o     <= '0;
      bus_wdata_o   <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      killed        <= 1'b0;
      ldata_o       <= '0;
      ldata_valid_o <= 1'b0;
    end else begin
      if (launch) begin
        bus_we_o    <= is_store;
        bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
        bus_sel_o   <= sel;
        bus_wdata_o <= wd;
        op_q        <= op_i;
        lane_q      <= addr_i[1:0];
      end
      killed        <= launch ? 1'b0 : (state == BUS && flush_i) ? 1'b1 : killed;
      ldata_o       <= ld_hit ? ext : ldata_o;
      ldata_valid_o <= ld_hit;
    end
endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Load/store sequencer for the MEM pipeline stage. It takes one memory operation per instruction from MEM, drives a single-port data bus with a req/ack handshake, and holds the pipeline through the pipeline-control stall request until the bus answers. On the bus side it generates big-endian byte-lane selects and replicated store data. On the pipeline side it returns sign- or zero-extended load data toward write-back. Misaligned addresses are caught before any bus access.

## Interface
Parameters:
- DATA_W, 32, data bus and register width (`RegBus`)
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  MEM holds a memory instruction this cycle
- op_i  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- addr_i  in  ADDR_W  effective byte address
- wdata_i  in  DATA_W  store source (rt)
- flush_i  in  1  exception flush of the MEM instruction
- bus_req_o  out  1  bus request, held until ack
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- bus_sel_o  out  4  byte enables, bit 3 = bits [31:24]
- bus_wdata_o  out  DATA_W  store data
- bus_ack_i  in  1  bus completion, one cycle
- bus_rdata_i  in  DATA_W  read data, valid with ack
- stallreq_o  out  1  stall request to pipeline control
- ldata_o  out  DATA_W  extended load result
- ldata_valid_o  out  1  ldata_o valid, one-cycle pulse
- misalign_o  out  1  address-error pulse

## Operation
- FSM states are IDLE, BUS and DONE. Reset state is IDLE.
- In IDLE:
  - If req_valid_i=1, flush_i=0 and the address is aligned, latch op, addr and wdata, then go to BUS.
  - Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. In that case pulse misalign_o for that cycle, make no bus access, assert no stall, and stay in IDLE.
- In BUS:
  - bus_req_o=1. All bus_* outputs come from latched values and stay stable until ack.
  - On bus_ack_i=1, register the extended load into ldata_o and go to DONE. If the operation was flushed, go to IDLE instead.
- In DONE: ldata_valid_o=1 for loads (0 for stores), stallreq_o=0, go to IDLE. The pipeline advances at the end of this cycle. DONE never launches a new access, even though req_valid_i is still high.
- stallreq_o = (IDLE & req_valid_i & aligned & !flush_i) | BUS. It is combinational and forced to 0 while rst=0.
- Lanes are big-endian:
  - Byte access: addr[1:0]=00→1000, 01→0100, 10→0010, 11→0001.
  - Halfword access: addr[1]=0→1100, addr[1]=1→0011.
  - Word access: 1111.
- Store data: SB replicates {4{wdata[7:0]}}, SH replicates {2{wdata[15:0]}}, SW passes wdata unchanged.
- Load data: extract the selected lane. LB and LH sign-extend from the lane MSB. LBU and LHU zero-extend. LW passes the word unchanged.
- Flush:
  - flush_i in IDLE suppresses the launch.
  - flush_i in BUS marks the operation killed. The handshake still completes (no abort on the bus) and stallreq_o stays high until ack. No ldata_valid_o pulse follows.
- Asserting reset mid-transaction returns immediately to IDLE and drops bus_req_o. The bus is required to discard an un-acked request on reset.

## Timing
- Reset values:
  - Every registered output is 0: bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, ldata_o, ldata_valid_o, misalign_o.
  - stallreq_o is 0.
- Best case (ack in the first BUS cycle): accept in cycle 0, request in cycle 1, DONE in cycle 2. The instruction spends 3 cycles in MEM, of which 2 are stall cycles.
- Each cycle of ack delay adds one stall cycle.
- bus_req_o rises in the cycle after acceptance. It falls in the cycle after ack.
- ldata_o changes only on ack of an un-flushed load. It holds its value otherwise.
- misalign_o is asserted in the same cycle as the offending req_valid_i.

## Test plan
- LB, addr 0x1001, rdata 0x11823344, ack on first BUS cycle → bus_sel_o=0100, bus_we_o=0, ldata_o=0xFFFFFF82 with ldata_valid_o pulse in cycle 2, stallreq_o high for cycles 0–1.
- LHU, addr 0x2002, rdata 0x1234ABCD → bus_sel_o=0011, ldata_o=0x0000ABCD. LH, addr 0x2000, same rdata → bus_sel_o=1100, ldata_o=0x00001234.
- SB, addr 0x3003, wdata 0x000000A5 → bus_we_o=1, bus_sel_o=0001, bus_wdata_o=0xA5A5A5A5, bus_addr_o=0x3000, no ldata_valid_o.
- LW, addr 0x4002 → misalign_o=1 for one cycle, bus_req_o stays 0, stallreq_o=0. SH, addr 0x4001 → same response.
- SW, addr 0x5000, ack delayed 3 cycles → bus_* outputs constant across all BUS cycles, stallreq_o high for 4 cycles, single bus_req_o→ack handshake.
- LW, flush_i raised in the second BUS cycle, ack in the third → stallreq_o held until ack, ldata_o unchanged, no ldata_valid_o. Separately, rst low mid-BUS → all outputs 0 immediately, FSM in IDLE.
